plmux_pipe_stage: RTL

- One column stage of a pipelined readback/merge daisy chain, the successor to the combinational per-column mux.
- Each stage registers a tagged token (column tag + data) coming from the previous column. It substitutes or ORs in local column data according to the tag, then forwards the token to the next column under valid/ready flow control.
- Generalised in data and column-ID widths. Adds backpressure, local-data stalls and a saturating token counter.

---
 rtl/plmux_pipe_stage.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/plmux_pipe_stage.sv
// -----------------------------------------------------------------------------
// plmux_pipe_stage
//
// One column stage of the pipelined readback/merge daisy chain. A tagged token
// (column tag + data) arrives from the previous column. The stage classifies
// it against its own column ID:
//   SEL   - tag matches COL_ID_i, or this is the last column: local data
//           replaces the token data.
//   BCAST - tag is zero and not SEL: local data is ORed into the token data.
//   PASS  - anything else: the token is forwarded untouched.
// The merged token is registered in a one-entry output slot and handed to the
// next column under valid/ready flow control. A saturating counter tracks how
// many tokens consumed local data.
//
// Optional feature macro: PLMUX_SKID_EN
//   When defined, a one-entry skid buffer sits in front of the merge logic so
//   that PREV_READY_o is a pure register output. Tokens that cannot go
//   straight to the output slot are parked raw in the skid. They are classified
//   and merged when they move to the output.
//   When undefined, PREV_READY_o is combinational and the stage stalls the
//   upstream column directly.
//
// Parameters:
//   DW    - token / local data width
//   CW    - column ID / tag width
//   CNT_W - merged-token counter width
//
// Ports:
//   CLK_i, RST_N_i          clock, synchronous active-low reset
//   LAST_COL_i, COL_ID_i    static straps (last column, column ID)
//   PREV_VALID_i/READY_o    upstream handshake
//   PREV_COL_i, PREV_DATA_i upstream token
//   MY_VALID_i, MY_READY_o  local data handshake (MY_READY_o is a 1-cycle pulse)
//   MY_COL_DATA_i           local column data
//   NEXT_VALID_o/READY_i    downstream handshake
//   NEXT_COL_o, NEXT_DATA_o downstream token
//   MERGE_CNT_o             saturating count of tokens that used local data
// -----------------------------------------------------------------------------
module plmux_pipe_stage #(
  parameter int DW    = 36,
  parameter int CW    = 10,
  parameter int CNT_W = 16
) (
  input  logic             CLK_i,
  input  logic             RST_N_i,
  input  logic             LAST_COL_i,
  input  logic [CW-1:0]    COL_ID_i,
  input  logic             PREV_VALID_i,
  output logic             PREV_READY_o,
  input  logic [CW-1:0]    PREV_COL_i,
  input  logic [DW-1:0]    PREV_DATA_i,
  input  logic             MY_VALID_i,
  output logic             MY_READY_o,
  input  logic [DW-1:0]    MY_COL_DATA_i,
  output logic             NEXT_VALID_o,
  input  logic             NEXT_READY_i,
  output logic [CW-1:0]    NEXT_COL_o,
  output logic [DW-1:0]    NEXT_DATA_o,
  output logic [CNT_W-1:0] MERGE_CNT_o
);

  // Candidate token that is being offered to the output slot this cycle.
  logic          cand_valid;
  logic [CW-1:0] cand_col;
  logic [DW-1:0] cand_data;

  logic          is_sel;
  logic          is_bcast;
  logic          need_local;
  logic [DW-1:0] result;
  logic          slot_free;
  logic          move;

`ifdef PLMUX_SKID_EN
  logic          skid_valid;
  logic [CW-1:0] skid_col;
  logic [DW-1:0] skid_data;
  logic          in_accept;

  // A parked skid token always has priority over new upstream traffic; while
  // the skid is full upstream is not accepted, so order is preserved.
  always_comb begin
    cand_valid = skid_valid | PREV_VALID_i;
    cand_col   = skid_valid ? skid_col  : PREV_COL_i;
    cand_data  = skid_valid ? skid_data : PREV_DATA_i;
  end
`else
  always_comb begin
    cand_valid = PREV_VALID_i;
    cand_col   = PREV_COL_i;
    cand_data  = PREV_DATA_i;
  end
`endif

  // SEL wins over BCAST, so column 0 seeing tag 0 replaces rather than ORs.
  always_comb begin
    is_sel     = LAST_COL_i | (cand_col == COL_ID_i);
    is_bcast   = !is_sel & (cand_col == '0);
    need_local = is_sel | is_bcast;
    if (is_sel) begin
      result = MY_COL_DATA_i;
    end else if (is_bcast) begin
      result = MY_COL_DATA_i | cand_data;
    end else begin
      result = cand_data;
    end
  end

  // A token only moves into the output slot when local data is present for it
  // (if needed), so an invalid local source is never merged.
  always_comb begin
    slot_free  = !NEXT_VALID_o | NEXT_READY_i;
    move       = RST_N_i & cand_valid & slot_free & (!need_local | MY_VALID_i);
    MY_READY_o = move & need_local;
  end

`ifdef PLMUX_SKID_EN
  assign PREV_READY_o = !skid_valid;
  assign in_accept    = PREV_VALID_i & !skid_valid;

  // The skid holds an upstream token that was accepted but could not reach the
  // output slot in the same cycle; it empties as soon as it moves out.
  always_ff @(posedge CLK_i) begin
    if (!RST_N_i) begin
      skid_valid <= 1'b0;
      skid_col   <= '0;
      skid_data  <= '0;
    end else if (skid_valid) begin
      if (move) begin
        skid_valid <= 1'b0;
      end
    end else if (in_accept && !move) begin
      skid_valid <= 1'b1;
      skid_col   <= PREV_COL_i;
      skid_data  <= PREV_DATA_i;
    end
  end
`else
  // Ready is gated by reset so nothing is handshaken while the stage is held.
  assign PREV_READY_o = RST_N_i & slot_free & (!need_local | MY_VALID_i);
`endif

  // Output slot: loading a new token wins over draining, so a simultaneous
  // drain and accept simply overwrites the register and keeps valid high.
  always_ff @(posedge CLK_i) begin
    if (!RST_N_i) begin
      NEXT_VALID_o <= 1'b0;
      NEXT_COL_o   <= '0;
      NEXT_DATA_o  <= '0;
    end else if (move) begin
      NEXT_VALID_o <= 1'b1;
      NEXT_COL_o   <= cand_col;
      NEXT_DATA_o  <= result;
    end else if (NEXT_READY_i) begin
      NEXT_VALID_o <= 1'b0;
    end
  end

  // Merge counter sticks at all-ones instead of wrapping.
  always_ff @(posedge CLK_i) begin
    if (!RST_N_i) begin
      MERGE_CNT_o <= '0;
    end else if (MY_READY_o && (MERGE_CNT_o != {CNT_W{1'b1}})) begin
      MERGE_CNT_o <= MERGE_CNT_o + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule
